// File: rtl/counter_tb_pkg.sv
// Shared definitions for the counter stimulus engine: mode codes, FSM encoding, LFSR constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_tb_pkg;

    // Counter mode codes carried on the 'mode' bus
    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_UP    = 3'd2;
    localparam state_t ST_DOWN  = 3'd3;
    localparam state_t ST_DOWN3 = 3'd4;
    localparam state_t ST_HOLD  = 3'd5;
    localparam state_t ST_CHECK = 3'd6;
    localparam state_t ST_DONE  = 3'd7;

    // Right-shifting Galois LFSR for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Expected-value register for the 4-mode counter, fed with the tester's own drive.
// Latency: exp_q/exp_load reflect the drive sampled at the previous posedge (same edge as the counter).
// Backpressure: none; follows the drive every cycle.
module counter_ref_model
    import counter_tb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] exp_q,
    output logic             exp_load
);

    // Mirror the counter: clear when disabled, otherwise load/up/down/down-by-3 with natural wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q    <= '0;
            exp_load <= 1'b0;
        end else if (!enable_) begin
            exp_q    <= '0;
            exp_load <= 1'b0;
        end else begin
            exp_load <= (mode == MODE_LOAD);
            case (mode)
                MODE_UP:    exp_q <= exp_q + WIDTH'(1);
                MODE_DOWN:  exp_q <= exp_q - WIDTH'(1);
                MODE_DOWN3: exp_q <= exp_q - WIDTH'(3);
                default:    exp_q <= D;
            endcase
        end
    end

endmodule

// File: rtl/counter_tester.sv
// Stimulus/checker engine: drives LOAD, UP, DOWN, DOWN3, HOLD phases into a counter and counts Q/load mismatches.
// Latency: drive registered 1 cycle after start; DUT result checked 1 cycle after it is registered; done 4*PHASE_LEN+3 cycles after start.
// Backpressure: none; start is a level sampled only in IDLE. Build option COUNTER_TESTER_LFSR_EN takes LOAD data from an LFSR.
module counter_tester
    import counter_tb_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               PHASE_LEN  = 4,
    parameter logic [WIDTH-1:0] LOAD_VALUE = WIDTH'(5)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             enable_,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q_dut,
    input  logic             load_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             err_flag
);

    localparam int CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    phase_cnt;
    logic             phase_last;
    logic             in_phase;
    logic             start_run;
    logic             chk_v;
    logic             mismatch;
    logic             err_hit;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] exp_q;
    logic             exp_load;

    assign phase_last = (phase_cnt == CW'(PHASE_LEN - 1));
    assign in_phase   = (state == ST_UP) || (state == ST_DOWN) ||
                        (state == ST_DOWN3) || (state == ST_HOLD);
    assign start_run  = (state == ST_IDLE) && start;

`ifdef COUNTER_TESTER_LFSR_EN
    logic [31:0] lfsr_q;

    // LFSR steps once per LOAD, after its current value has been driven
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (state == ST_LOAD) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign load_data = WIDTH'(lfsr_q);
`else
    assign load_data = LOAD_VALUE;
`endif

    // Phase sequencing; start is only honoured from IDLE, and DONE waits for start to drop
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)      state_nxt = ST_LOAD;
            ST_LOAD:                  state_nxt = ST_UP;
            ST_UP:    if (phase_last) state_nxt = ST_DOWN;
            ST_DOWN:  if (phase_last) state_nxt = ST_DOWN3;
            ST_DOWN3: if (phase_last) state_nxt = ST_HOLD;
            ST_HOLD:  if (phase_last) state_nxt = ST_CHECK;
            ST_CHECK:                 state_nxt = ST_DONE;
            ST_DONE:  if (!start)     state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // State register and per-phase cycle counter (restarts on every state change)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if (in_phase) begin
                phase_cnt <= phase_cnt + CW'(1);
            end
        end
    end

    // Registered drive decoded from the next state so it lines up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_ <= 1'b0;
            mode    <= MODE_UP;
            D       <= '0;
            busy    <= 1'b0;
        end else begin
            enable_ <= 1'b0;
            mode    <= MODE_UP;
            D       <= '0;
            busy    <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            case (state_nxt)
                ST_LOAD: begin
                    enable_ <= 1'b1;
                    mode    <= MODE_LOAD;
                    D       <= load_data;
                end
                ST_UP: begin
                    enable_ <= 1'b1;
                    mode    <= MODE_UP;
                end
                ST_DOWN: begin
                    enable_ <= 1'b1;
                    mode    <= MODE_DOWN;
                end
                ST_DOWN3: begin
                    enable_ <= 1'b1;
                    mode    <= MODE_DOWN3;
                end
                default: ;
            endcase
        end
    end

    counter_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .clk      (clk),
        .reset    (reset),
        .enable_  (enable_),
        .mode     (mode),
        .D        (D),
        .exp_q    (exp_q),
        .exp_load (exp_load)
    );

    assign mismatch = (Q_dut != exp_q) || (load_dut != exp_load);
    assign err_hit  = chk_v && mismatch;

    // Compare window opens one edge after the LOAD drive and closes on the edge entering DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_v <= 1'b0;
        end else if (state == ST_LOAD) begin
            chk_v <= 1'b1;
        end else if (state == ST_CHECK) begin
            chk_v <= 1'b0;
        end
    end

    // Mismatch accounting and verdict; CHECK's edge still carries the final compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
            err_flag  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            err_flag <= err_hit;
            if (start_run) begin
                err_count <= '0;
                done      <= 1'b0;
                pass      <= 1'b0;
            end else begin
                if (err_hit && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + 16'd1;
                end
                if (state == ST_CHECK) begin
                    done <= 1'b1;
                    pass <= (err_count == 16'd0) && !err_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_tester.sv
// Bench for counter_tester: behavioural counter on the DUT side plus a phase-arithmetic expectation model.
// Latency: checks sampled 1 time unit after each posedge.
// Backpressure: n/a.
module tb_counter_tester;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        enable_, enable_w;
    logic [1:0]  mode, mode_w;
    logic [31:0] D, D_w;
    logic [31:0] Q_dut, Q_w;
    logic        load_dut, load_w;
    logic        busy, done, pass, err_flag;
    logic        busy_w, done_w, pass_w, err_flag_w;
    logic [15:0] err_count, err_count_w;

    logic [31:0] cnt_q = '0, cnt_w = '0;
    logic        cnt_ld = 1'b0, cnt_ld_w = 1'b0;
    logic [31:0] corrupt_q;
    logic        corrupt_ld;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ld_main, ld_wrap;

    always #5 clk = ~clk;

    counter_tester #(.WIDTH(32), .PHASE_LEN(P), .LOAD_VALUE(32'd5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .enable_(enable_), .mode(mode), .D(D),
        .Q_dut(Q_dut), .load_dut(load_dut), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .err_flag(err_flag)
    );

    counter_tester #(.WIDTH(32), .PHASE_LEN(P), .LOAD_VALUE(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .enable_(enable_w), .mode(mode_w), .D(D_w),
        .Q_dut(Q_w), .load_dut(load_w), .busy(busy_w), .done(done_w), .pass(pass_w),
        .err_count(err_count_w), .err_flag(err_flag_w)
    );

    // Behavioural 4-mode counters standing in for the devices under stimulus
    always @(posedge clk) begin
        if (!enable_) begin
            cnt_q <= '0; cnt_ld <= 1'b0;
        end else begin
            cnt_ld <= (mode == 2'b11);
            case (mode)
                2'b00:   cnt_q <= cnt_q + 32'd1;
                2'b01:   cnt_q <= cnt_q - 32'd1;
                2'b10:   cnt_q <= cnt_q - 32'd3;
                default: cnt_q <= D;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!enable_w) begin
            cnt_w <= '0; cnt_ld_w <= 1'b0;
        end else begin
            cnt_ld_w <= (mode_w == 2'b11);
            case (mode_w)
                2'b00:   cnt_w <= cnt_w + 32'd1;
                2'b01:   cnt_w <= cnt_w - 32'd1;
                2'b10:   cnt_w <= cnt_w - 32'd3;
                default: cnt_w <= D_w;
            endcase
        end
    end

    assign Q_dut    = cnt_q ^ corrupt_q;
    assign load_dut = cnt_ld ^ corrupt_ld;
    assign Q_w      = cnt_w;
    assign load_w   = cnt_ld_w;

`ifdef COUNTER_TESTER_LFSR_EN
    function automatic logic [31:0] next_load(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction
`endif

    task automatic reset_loads();
`ifdef COUNTER_TESTER_LFSR_EN
        ld_main = 32'hACE1_0001;
        ld_wrap = 32'hACE1_0001;
`else
        ld_main = 32'd5;
        ld_wrap = 32'hFFFF_FFFE;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".enable_"},   {31'd0, enable_},  32'd0);
        chk({tag, ".mode"},      {30'd0, mode},     32'd0);
        chk({tag, ".D"},         D,                 32'd0);
        chk({tag, ".busy"},      {31'd0, busy},     32'd0);
        chk({tag, ".done"},      {31'd0, done},     32'd0);
        chk({tag, ".pass"},      {31'd0, pass},     32'd0);
        chk({tag, ".err_count"}, {16'd0, err_count}, 32'd0);
        chk({tag, ".err_flag"},  {31'd0, err_flag}, 32'd0);
    endtask

    // One run from IDLE. sel bit k corrupts what the counter presents after edge k;
    // errors are expected only for presentations compared inside the check window.
    task automatic do_run(input string name, input logic [31:0] sel, input int pulse_k,
                          input int hold, input logic stuck_down, input int abort_k,
                          output int errs);
        int          last, seg, r;
        logic        bad_prev, exp_en, exp_busy, exp_done, exp_flag;
        logic [1:0]  exp_mode;
        logic [31:0] exp_d, ld;
        last     = 4 * P + 3 + hold;
        errs     = 0;
        bad_prev = 1'b0;
        ld       = ld_main;
        start    = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            exp_flag = bad_prev && (k - 1 >= 1) && (k - 1 <= 4 * P + 1);
            if (exp_flag) errs++;
            exp_en = 1'b0; exp_mode = 2'b00; exp_d = '0;
            if (k == 0) begin
                exp_en = 1'b1; exp_mode = 2'b11; exp_d = ld;
            end else if (k <= 4 * P) begin
                seg = (k - 1) / P;
                if (seg < 3) begin
                    exp_en   = 1'b1;
                    exp_mode = 2'(seg);
                end
            end
            exp_busy = (k <= 4 * P + 1);
            exp_done = (k >= 4 * P + 2);
            chk({name, ".enable_"},   {31'd0, enable_},   {31'd0, exp_en});
            chk({name, ".mode"},      {30'd0, mode},      {30'd0, exp_mode});
            chk({name, ".D"},         D,                  exp_d);
            chk({name, ".busy"},      {31'd0, busy},      {31'd0, exp_busy});
            chk({name, ".done"},      {31'd0, done},      {31'd0, exp_done});
            chk({name, ".err_flag"},  {31'd0, err_flag},  {31'd0, exp_flag});
            chk({name, ".err_count"}, {16'd0, err_count}, errs);
            if (exp_done) chk({name, ".pass"}, {31'd0, pass}, {31'd0, errs == 0});
            if (k == 1)         chk({name, ".q_after_load"},  cnt_q, ld);
            if (k == P + 1)     chk({name, ".q_after_up"},    cnt_q, ld + P);
            if (k == 2 * P + 1) chk({name, ".q_after_down"},  cnt_q, ld);
            if (k == 3 * P + 1) chk({name, ".q_after_down3"}, cnt_q, ld - 3 * P);
            if (k == 4 * P + 1) chk({name, ".q_after_hold"},  cnt_q, 32'd0);
            if (k == P + 1)     chk({name, ".wrap_q_after_up"}, cnt_w, ld_wrap + P);
            if (k == 4 * P + 2) begin
                chk({name, ".wrap_done"}, {31'd0, done_w}, 32'd1);
                chk({name, ".wrap_pass"}, {31'd0, pass_w}, 32'd1);
                chk({name, ".wrap_errs"}, {16'd0, err_count_w}, 32'd0);
            end
`ifdef COUNTER_TESTER_LFSR_EN
            if (k == 0) begin
                ld_main = next_load(ld_main);
                ld_wrap = next_load(ld_wrap);
            end
`endif
            if (k == abort_k) begin
                corrupt_q = '0; corrupt_ld = 1'b0; start = 1'b0;
                reset = 1'b0;
                return;
            end
            start = (k == pulse_k) || (k >= 4 * P + 1 && k < 4 * P + 1 + hold);
            corrupt_q = '0; corrupt_ld = 1'b0;
            if (stuck_down && k >= P + 2 && k <= 2 * P + 1) begin
                corrupt_q = {31'd0, ~cnt_q[0]};
            end else if (k < 32 && sel[k]) begin
                r = $urandom_range(0, 2);
                if (r != 1) corrupt_q = $urandom() | 32'd1;
                if (r != 0) corrupt_ld = 1'b1;
            end
            bad_prev = (corrupt_q != 0) || corrupt_ld;
        end
    endtask

    initial begin
        int errs;
        reset = 1'b0; start = 1'b0; corrupt_q = '0; corrupt_ld = 1'b0;
        reset_loads();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        do_run("golden", 32'd0, -1, 0, 1'b0, -1, errs);
        chk("golden.final_errs", {16'd0, err_count}, 32'd0);
        chk("golden.final_pass", {31'd0, pass}, 32'd1);

        do_run("hold_start", 32'd0, -1, 5, 1'b0, -1, errs);
        do_run("pulse_in_up", 32'd0, 2, 0, 1'b0, -1, errs);

        for (int i = 0; i < 5; i++) begin
            do_run("random", $urandom() & 32'h00FF_FFFF, -1, 0, 1'b0, -1, errs);
        end
        do_run("edges", 32'h0006_0003, -1, 0, 1'b0, -1, errs);
        chk("edges.count", {16'd0, err_count}, 32'd2);

        do_run("stuck_down", 32'd0, -1, 0, 1'b1, -1, errs);
        chk("stuck_down.count", {16'd0, err_count}, 32'd2);
        chk("stuck_down.pass", {31'd0, pass}, 32'd0);

        do_run("abort", 32'd0, -1, 0, 1'b0, 6, errs);
        reset_loads();
        @(posedge clk); #1;
        chk_reset_values("abort_reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.done_never", {31'd0, done}, 32'd0);
        chk("abort.busy_idle", {31'd0, busy}, 32'd0);
        do_run("after_abort", 32'd0, -1, 0, 1'b0, -1, errs);
        chk("after_abort.pass", {31'd0, pass}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/counter_tester.md
# counter_tester

Self-checking stimulus engine for the 4-mode 32-bit counter: it drives `enable_`, `mode` and `D` through a fixed phase sequence and keeps its own expected-value model. Every cycle it compares the counter's `Q` and `load` outputs against that model, then reports a mismatch count and a pass/fail verdict. It sits on the testbench/BIST side of the counter interface, as the driving end of the signals the counter consumes.

## Interface
- `WIDTH`, 32, counter data width
- `PHASE_LEN`, 4, cycles spent in each count/hold phase (≥1)
- `LOAD_VALUE`, 5, value driven on `D` during LOAD (fixed-pattern build)
- `clk` in 1, sole clock, all state on posedge
- `reset` in 1, asynchronous, active-low; clears all state
- `start` in 1, level, sampled in IDLE only
- `enable_` out 1, counter enable
- `mode` out 2, 00 up, 01 down, 10 down-by-3, 11 load
- `D` out WIDTH, load data
- `Q_dut` in WIDTH, counter output
- `load_dut` in 1, counter load flag
- `busy` out 1, sequence running
- `done` out 1, sequence finished (held until next start)
- `pass` out 1, valid when `done`=1; 1 iff `err_count`=0
- `err_count` out 16, mismatch count, saturates at 16'hFFFF
- `err_flag` out 1, one-cycle pulse on each mismatch

## Operation
- FSM states: IDLE → LOAD (1 cycle) → UP → DOWN → DOWN3 → HOLD (PHASE_LEN cycles each) → CHECK (1 cycle) → DONE.
- DONE → IDLE when `start`=0. IDLE → LOAD on `start`=1, which also clears `err_count`, `done` and `pass`.
- Drive per state:
  - IDLE/DONE/CHECK: `enable_`=0, `mode`=00, `D`=0.
  - LOAD: `enable_`=1, `mode`=11, `D`=load data.
  - UP/DOWN/DOWN3: `enable_`=1, `mode`=00/01/10 respectively.
  - HOLD: `enable_`=0.
- Expected model, updated on the same edge the DUT samples the drive:
  - `exp_q`: load→D, up→+1, down→−1, down3→−3, all modulo 2^WIDTH (wrap both directions).
  - `exp_q`←0 whenever `enable_`=0.
  - `exp_load`=1 only after a load cycle, else 0.
- Check enable `chk_v` is set on the edge after the first non-IDLE drive and cleared in DONE.
- When `chk_v`=1, each posedge compares `Q_dut`==`exp_q` and `load_dut`==`exp_load`. Any inequality gives one `err_flag` pulse and `err_count`+1, with a single increment per cycle even if both fields differ.
- `rco` is not checked: the counter clears it on negedge, so it is not stable at posedge.
- `start` in any state other than IDLE is ignored.
- `reset` low mid-sequence: immediate return to IDLE. Outputs take reset values and the check is abandoned without setting `done`.

## Timing
- Reset values: `enable_`=0, `mode`=00, `D`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_flag`=0.
- Drive outputs are registered: 1 cycle from `start` sampled to the LOAD drive.
- Compare latency: a DUT result registered at edge k is checked at edge k+1.
- The CHECK state absorbs the last compare. `done` and `pass` rise together at the edge entering DONE.
- Total run: 4·PHASE_LEN+3 cycles from `start` to `done`.
- `busy`=1 from LOAD through CHECK inclusive.

## Configuration
- `COUNTER_TESTER_LFSR_EN`
  - Defined: LOAD data comes from a WIDTH-bit Galois LFSR (taps for x^32+x^22+x^2+x+1, seed 32'hACE1_0001 on reset). The LFSR advances once per LOAD.
  - Undefined: LOAD data is `LOAD_VALUE`, with no LFSR logic.

## Structure
- Shared package `counter_tb_pkg`:
  - mode encodings `MODE_UP`/`MODE_DOWN`/`MODE_DOWN3`/`MODE_LOAD`
  - FSM state enum
  - LFSR seed and taps constants
- One sub-module, `counter_ref_model`: the expected-value register (`exp_q`, `exp_load`), fed with the same `enable_`/`mode`/`D` the tester drives.

## Test plan
- Golden run, correct DUT, LOAD_VALUE=5, PHASE_LEN=4:
  - Expected Q after each phase: 5, 9, 5, 32'hFFFF_FFF9, 0.
  - `done`=1 and `pass`=1 after 19 cycles; `err_count`=0.
- Wrap, LOAD_VALUE=32'hFFFF_FFFE: after UP, expected Q=32'h0000_0002. A correct DUT gives `pass`=1.
- Fault injection, DUT `Q` bit0 stuck-at-1 during the DOWN phase:
  - `err_flag` pulses on mismatching cycles.
  - Final `err_count`=2; `pass`=0.
- `reset` driven low on cycle 7 of a run:
  - All outputs at reset values next cycle; `done` is never set.
  - A new `start` completes a normal run.
- `start` pulsed again during UP: no effect on sequence or timing. `start` held high after DONE: remains in DONE until `start`=0.
- `COUNTER_TESTER_LFSR_EN` defined: first LOAD drives `D`=32'hACE1_0001, and a correct DUT passes.
